// File: rtl/fifo_dc_pop_port.sv
// Pop-side port of a dual-clock FIFO: issues RAM reads and re-times rdata into a 2-entry skid queue.
// Latency: pop in cycle N gives out_valid in cycle N+2; full throughput under out_ready; backpressure stops popping.
module fifo_dc_pop_port #(
   parameter int NUM_ENTRIES = 16,
   parameter int DATA_W      = 32
) (
   input  logic              clk_pop,
   input  logic              rst_n,
   input  logic              empty_ff,
   output logic              pop,
   output logic              re,
   input  logic [DATA_W-1:0] rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_e;

   if (NUM_ENTRIES < 2) begin : g_depth_check
      $error("fifo_dc_pop_port: NUM_ENTRIES must be at least 2");
   end

   logic [1:0]        rst_sync_q;
   logic              rst_loc;
   logic              inflight_q;
   logic              rd_req;
   logic              deq;
   logic              cap;
   logic [2:0]        load;
   logic [2:0]        room;
   buf_state_e        state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;

   // Local reset asserts with rst_n and releases two clk_pop edges later.
   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_loc = ~rst_sync_q[1];

   assign deq = out_valid & out_ready;
   assign cap = inflight_q;

   // Occupancy after this cycle, counting the word already in flight from the RAM.
   assign load   = {1'b0, out_count} + {2'b00, inflight_q};
   assign room   = {2'b00, deq} + 3'd1;
   assign rd_req = ~empty_ff & ~rst_loc & (load <= room);

   assign pop = rd_req;
   assign re  = rd_req;

   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_req;
      end
   end

   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (cap) begin
               state_d = ONE;
               head_d  = rdata;
            end
         end
         ONE: begin
            if (cap && !deq) begin
               state_d = TWO;
               tail_d  = rdata;
            end else if (cap && deq) begin
               head_d = rdata;
            end else if (deq) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (deq) begin
               head_d = tail_q;
               if (cap) begin
                  tail_d = rdata;
               end else begin
                  state_d = ONE;
               end
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (rst_loc) begin
         state_d = EMPTY;
         head_d  = '0;
         tail_d  = '0;
      end
   end

   assign out_valid = (state_q != EMPTY);
   assign out_count = state_q;
   assign out_data  = head_q;

   // The read-issue condition never lets a word land on a full, stalled queue.
   a_no_overflow : assert property (@(posedge clk_pop) disable iff (!rst_n || rst_loc)
      !(state_q == TWO && cap && !deq));

endmodule
